// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv2 control path.
//   state_e    : sequencer FSM states
//   max1clog2  : $clog2 clamped to a minimum of 1 bit, used for index widths
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTap,
    StLat,
    StOut,
    StDone
  } state_e;

  // An index that only ever holds 0 (n = 1) still needs a 1-bit port.
  function automatic int unsigned max1clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv2_idx2d_counter.sv
// 2-D row/col index counter over an N x N grid. col is the inner index.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clr          : synchronous clear to (0,0); has priority over inc
//   inc          : advance col; wrap col to 0 and advance row; the last
//                  point (N-1,N-1) wraps back to (0,0)
//   row, col     : current indices
//   last         : current point is (N-1,N-1)
module conv2_idx2d_counter #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         last
);

  localparam logic [W-1:0] Max = W'(N - 1);

  logic col_end;

  assign col_end = (col == Max);
  assign last    = col_end && (row == Max);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv2_window_sequencer.sv
// Walks every valid output position of a SIZE x SIZE image and, per position,
// issues the SIZEKer x SIZEKer image/kernel tap addresses to the MAC, waits
// MAC_LAT cycles for the result and presents it under valid/ready.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   start                 : begin one image (only seen in idle)
//   busy, done            : busy from cycle after start through done; done is a 1-cycle pulse
//   tap_valid             : tap addresses valid, MAC accumulates
//   acc_clr, acc_last     : first / last tap of a position
//   img_row/img_col       : image tap address (out_* + k*)
//   ker_row/ker_col       : kernel tap address
//   out_row/out_col       : position being computed / presented
//   out_valid, out_ready  : result handshake
module conv2_window_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned SIZE    = 320,
  parameter int unsigned SIZEKer = 3,
  parameter int unsigned MAC_LAT = 2,
  localparam int unsigned N_OUT  = SIZE - SIZEKer + 1,
  localparam int unsigned AW     = max1clog2(SIZE),
  localparam int unsigned OW     = max1clog2(N_OUT),
  localparam int unsigned KW     = max1clog2(SIZEKer)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          tap_valid,
  output logic          acc_clr,
  output logic          acc_last,
  output logic [AW-1:0] img_row,
  output logic [AW-1:0] img_col,
  output logic [KW-1:0] ker_row,
  output logic [KW-1:0] ker_col,
  output logic [OW-1:0] out_row,
  output logic [OW-1:0] out_col,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int unsigned LW = max1clog2(MAC_LAT);

  if (SIZEKer < 1 || SIZEKer > SIZE) begin : g_bad_kernel
    $fatal(1, "conv2_window_sequencer: SIZEKer must be in 1..SIZE");
  end

  state_e        state_q, state_d;
  logic [LW-1:0] lat_q;
  logic          cnt_clr, tap_inc, pos_inc;
  logic          tap_last, pos_last;

  conv2_idx2d_counter #(
    .N (SIZEKer),
    .W (KW)
  ) u_tap_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (tap_inc),
    .row   (ker_row),
    .col   (ker_col),
    .last  (tap_last)
  );

  conv2_idx2d_counter #(
    .N (N_OUT),
    .W (OW)
  ) u_pos_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (pos_inc),
    .row   (out_row),
    .col   (out_col),
    .last  (pos_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= (state_q == StLat) ? lat_q + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    tap_inc = 1'b0;
    pos_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StTap;
          cnt_clr = 1'b1;
        end
      end
      StTap: begin
        // Kernel counter wraps to (0,0) on the last tap, ready for the next position.
        tap_inc = 1'b1;
        if (tap_last) state_d = (MAC_LAT == 0) ? StOut : StLat;
      end
      StLat: begin
        if (lat_q == LW'(MAC_LAT - 1)) state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          if (pos_last) begin
            state_d = StDone;
          end else begin
            pos_inc = 1'b1;
            state_d = StTap;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode only registered state and counters.
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign tap_valid = (state_q == StTap);
  assign out_valid = (state_q == StOut);
  assign acc_clr   = tap_valid && (ker_row == '0) && (ker_col == '0);
  assign acc_last  = tap_valid && tap_last;
  assign img_row   = AW'(out_row) + AW'(ker_row);
  assign img_col   = AW'(out_col) + AW'(ker_col);

endmodule

// File: tb/tb_conv2_window_sequencer.sv
// Self-checking bench for conv2_window_sequencer. Three instances cover the
// main configuration (5/3/2) and the SIZEKer=1/MAC_LAT=0 and SIZEKer=SIZE corners.
module tb_conv2_window_sequencer;

  typedef struct {
    int busy; int done; int tv; int clr; int last;
    int ir; int ic; int kr; int kc; int ov; int orow; int ocol;
  } rec_t;

  typedef struct {
    int t; int tv; int ir; int ic; int clr; int last; int ov; int orow; int ocol; int done;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  logic start0, start1, start2, rdy0, rdy1, rdy2;

  logic       busy0, done0, tv0, clr0, last0, ov0;
  logic [2:0] ir0, ic0;
  logic [1:0] kr0, kc0, or0, oc0;

  logic       busy1, done1, tv1, clr1, last1, ov1;
  logic [1:0] ir1, ic1, or1, oc1;
  logic [0:0] kr1, kc1;

  logic       busy2, done2, tv2, clr2, last2, ov2;
  logic [1:0] ir2, ic2, kr2, kc2;
  logic [0:0] or2, oc2;

  conv2_window_sequencer #(.SIZE(5), .SIZEKer(3), .MAC_LAT(2)) dut0 (
    .clock(clock), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .tap_valid(tv0), .acc_clr(clr0), .acc_last(last0), .img_row(ir0), .img_col(ic0),
    .ker_row(kr0), .ker_col(kc0), .out_row(or0), .out_col(oc0), .out_valid(ov0),
    .out_ready(rdy0)
  );

  conv2_window_sequencer #(.SIZE(4), .SIZEKer(1), .MAC_LAT(0)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .tap_valid(tv1), .acc_clr(clr1), .acc_last(last1), .img_row(ir1), .img_col(ic1),
    .ker_row(kr1), .ker_col(kc1), .out_row(or1), .out_col(oc1), .out_valid(ov1),
    .out_ready(rdy1)
  );

  conv2_window_sequencer #(.SIZE(3), .SIZEKer(3), .MAC_LAT(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .tap_valid(tv2), .acc_clr(clr2), .acc_last(last2), .img_row(ir2), .img_col(ic2),
    .ker_row(kr2), .ker_col(kc2), .out_row(or2), .out_col(oc2), .out_valid(ov2),
    .out_ready(rdy2)
  );

  int   n_checks = 0;
  int   n_fails  = 0;
  rec_t expq[$];
  rec_t hist[$];

  function automatic rec_t get_obs(input int inst);
    rec_t r;
    case (inst)
      0: r = '{int'(busy0), int'(done0), int'(tv0), int'(clr0), int'(last0), int'(ir0),
               int'(ic0), int'(kr0), int'(kc0), int'(ov0), int'(or0), int'(oc0)};
      1: r = '{int'(busy1), int'(done1), int'(tv1), int'(clr1), int'(last1), int'(ir1),
               int'(ic1), int'(kr1), int'(kc1), int'(ov1), int'(or1), int'(oc1)};
      default: r = '{int'(busy2), int'(done2), int'(tv2), int'(clr2), int'(last2), int'(ir2),
               int'(ic2), int'(kr2), int'(kc2), int'(ov2), int'(or2), int'(oc2)};
    endcase
    return r;
  endfunction

  task automatic drive_start(input int inst, input logic v);
    case (inst)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic drive_rdy(input int inst, input logic v);
    case (inst)
      0: rdy0 = v;
      1: rdy1 = v;
      default: rdy2 = v;
    endcase
  endtask

  task automatic check_eq(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic bit rec_match(input rec_t a, input rec_t e);
    bit ok;
    ok = (a.busy == e.busy) && (a.done == e.done) && (a.tv == e.tv) && (a.ov == e.ov) &&
         (a.clr == e.clr) && (a.last == e.last);
    if (e.tv != 0)
      ok = ok && (a.ir == e.ir) && (a.ic == e.ic) && (a.kr == e.kr) && (a.kc == e.kc);
    if (e.busy != 0 && e.done == 0)
      ok = ok && (a.orow == e.orow) && (a.ocol == e.ocol);
    return ok;
  endfunction

  task automatic check_rec(input string name, input int t, input rec_t a, input rec_t e);
    n_checks++;
    if (!rec_match(a, e)) begin
      n_fails++;
      if (n_fails <= 20)
        $display("FAIL %s cycle %0d: got busy=%0d done=%0d tv=%0d clr=%0d last=%0d img=(%0d,%0d) ker=(%0d,%0d) ov=%0d pos=(%0d,%0d); expected busy=%0d done=%0d tv=%0d clr=%0d last=%0d img=(%0d,%0d) ker=(%0d,%0d) ov=%0d pos=(%0d,%0d)",
                 name, t, a.busy, a.done, a.tv, a.clr, a.last, a.ir, a.ic, a.kr, a.kc, a.ov,
                 a.orow, a.ocol, e.busy, e.done, e.tv, e.clr, e.last, e.ir, e.ic, e.kr, e.kc,
                 e.ov, e.orow, e.ocol);
    end
  endtask

  // Reference: the whole image as a flat list of per-cycle expectations.
  task automatic build_model(input int size, input int k, input int lat);
    int   n;
    rec_t r;
    expq.delete();
    n = size - k + 1;
    for (int pr = 0; pr < n; pr++) begin
      for (int pc = 0; pc < n; pc++) begin
        for (int ki = 0; ki < k; ki++) begin
          for (int kj = 0; kj < k; kj++) begin
            r = '{busy: 1, done: 0, tv: 1, clr: int'(ki == 0 && kj == 0),
                  last: int'(ki == k - 1 && kj == k - 1), ir: pr + ki, ic: pc + kj,
                  kr: ki, kc: kj, ov: 0, orow: pr, ocol: pc};
            expq.push_back(r);
          end
        end
        for (int l = 0; l < lat; l++) begin
          r = '{busy: 1, done: 0, tv: 0, clr: 0, last: 0, ir: 0, ic: 0, kr: 0, kc: 0,
                ov: 0, orow: pr, ocol: pc};
          expq.push_back(r);
        end
        r = '{busy: 1, done: 0, tv: 0, clr: 0, last: 0, ir: 0, ic: 0, kr: 0, kc: 0,
              ov: 1, orow: pr, ocol: pc};
        expq.push_back(r);
      end
    end
    r = '{busy: 1, done: 1, tv: 0, clr: 0, last: 0, ir: 0, ic: 0, kr: 0, kc: 0,
          ov: 0, orow: n - 1, ocol: n - 1};
    expq.push_back(r);
  endtask

  // mode 0: out_ready always 1; mode 1: random out_ready; mode 2: 5-cycle stall at stall_idx.
  // noisy: random start pulses while busy, and start high during the done cycle.
  task automatic run_image(input int inst, input int size, input int k, input int lat,
                           input int mode, input int stall_idx, input bit noisy,
                           output int done_t);
    int   idx, t, stalls, n;
    rec_t a, e;
    logic rdy, st;
    build_model(size, k, lat);
    n = size - k + 1;
    hist.delete();
    idx = 0;
    stalls = 0;
    done_t = -1;
    @(posedge clock); #1;
    drive_start(inst, 1'b1);
    drive_rdy(inst, 1'b1);
    @(negedge clock);
    a = get_obs(inst);
    check_eq("idle_before_start", a.busy + a.done + a.tv + a.ov, 0);
    @(posedge clock); #1;
    t = 1;
    while (idx < expq.size() && t < 5000) begin
      e = expq[idx];
      rdy = 1'b1;
      if (mode == 1) rdy = ($urandom_range(0, 2) != 0);
      else if (mode == 2 && e.ov != 0 && e.orow * n + e.ocol == stall_idx && stalls < 5) begin
        rdy = 1'b0;
        stalls++;
      end
      drive_rdy(inst, rdy);
      st = 1'b0;
      if (noisy) st = (e.done != 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      drive_start(inst, st);
      @(negedge clock);
      a = get_obs(inst);
      hist.push_back(a);
      check_rec("sequence", t, a, e);
      if (e.done != 0) done_t = t;
      if (!(e.ov != 0 && !rdy)) idx++;
      @(posedge clock); #1;
      t++;
    end
    drive_start(inst, 1'b0);
    drive_rdy(inst, 1'b1);
    if (idx < expq.size()) check_eq("image_timeout", idx, expq.size());
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      a = get_obs(inst);
      check_eq("idle_after_done", a.busy + a.done + a.tv + a.ov, 0);
      @(posedge clock); #1;
    end
  endtask

  vec_t tab[12];
  int   dt;
  rec_t a;

  initial begin
    // Hand-derived samples of the 5/3/2 run with out_ready held high (cycle 1 = first tap).
    tab[0]  = '{1,   1, 0, 0, 1, 0, 0, 0, 0, 0};
    tab[1]  = '{2,   1, 0, 1, 0, 0, 0, 0, 0, 0};
    tab[2]  = '{3,   1, 0, 2, 0, 0, 0, 0, 0, 0};
    tab[3]  = '{4,   1, 1, 0, 0, 0, 0, 0, 0, 0};
    tab[4]  = '{9,   1, 2, 2, 0, 1, 0, 0, 0, 0};
    tab[5]  = '{10,  0, -1, -1, 0, 0, 0, 0, 0, 0};
    tab[6]  = '{12,  0, -1, -1, 0, 0, 1, 0, 0, 0};
    tab[7]  = '{13,  1, 0, 1, 1, 0, 0, 0, 1, 0};
    tab[8]  = '{61,  1, 1, 2, 1, 0, 0, 1, 2, 0};
    tab[9]  = '{69,  1, 3, 4, 0, 1, 0, 1, 2, 0};
    tab[10] = '{108, 0, -1, -1, 0, 0, 1, 2, 2, 0};
    tab[11] = '{109, 0, -1, -1, 0, 0, 0, -1, -1, 1};

    reset = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      a = get_obs(i);
      check_eq($sformatf("reset_outputs_%0d", i), a.busy + a.done + a.tv + a.clr + a.last +
               a.ir + a.ic + a.kr + a.kc + a.ov + a.orow + a.ocol, 0);
    end
    reset = 1'b0;

    run_image(0, 5, 3, 2, 0, -1, 1'b0, dt);
    check_eq("done_cycle_main", dt, 109);
    for (int i = 0; i < 12; i++) begin
      if (tab[i].t <= hist.size()) begin
        a = hist[tab[i].t - 1];
        n_checks++;
        if (a.tv != tab[i].tv || a.clr != tab[i].clr || a.last != tab[i].last ||
            a.ov != tab[i].ov || a.done != tab[i].done ||
            (tab[i].ir >= 0 && (a.ir != tab[i].ir || a.ic != tab[i].ic)) ||
            (tab[i].orow >= 0 && (a.orow != tab[i].orow || a.ocol != tab[i].ocol))) begin
          n_fails++;
          $display("FAIL table cycle %0d: got tv=%0d img=(%0d,%0d) clr=%0d last=%0d ov=%0d pos=(%0d,%0d) done=%0d; expected tv=%0d img=(%0d,%0d) clr=%0d last=%0d ov=%0d pos=(%0d,%0d) done=%0d",
                   tab[i].t, a.tv, a.ir, a.ic, a.clr, a.last, a.ov, a.orow, a.ocol, a.done,
                   tab[i].tv, tab[i].ir, tab[i].ic, tab[i].clr, tab[i].last, tab[i].ov,
                   tab[i].orow, tab[i].ocol, tab[i].done);
        end
      end else begin
        check_eq("table_history_length", hist.size(), tab[i].t);
      end
    end

    // Backpressure: 5 stall cycles at output (1,1) -> index 4.
    run_image(0, 5, 3, 2, 2, 4, 1'b0, dt);
    check_eq("done_cycle_stall", dt, 114);

    // Random backpressure with spurious start pulses.
    run_image(0, 5, 3, 2, 1, -1, 1'b1, dt);
    check_eq("done_seen_random", int'(dt > 0), 1);

    // Reset during the taps of position (2,0).
    @(posedge clock); #1;
    start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    for (int t = 1; t <= 75; t++) begin
      @(negedge clock);
      if (done0) check_eq("no_done_before_abort", int'(done0), 0);
      if (t == 75) begin
        a = get_obs(0);
        check_eq("abort_point_tap", a.tv, 1);
        check_eq("abort_point_pos", a.orow * 10 + a.ocol, 20);
      end
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(negedge clock);
    a = get_obs(0);
    check_eq("abort_busy_tap_done", a.busy + a.tv + a.done, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_eq("abort_no_done", int'(done0), 0);
    run_image(0, 5, 3, 2, 0, -1, 1'b0, dt);
    check_eq("done_cycle_after_abort", dt, 109);

    // SIZEKer=1, MAC_LAT=0, SIZE=4.
    run_image(1, 4, 1, 0, 0, -1, 1'b0, dt);
    check_eq("done_cycle_k1", dt, 33);
    run_image(1, 4, 1, 0, 1, -1, 1'b1, dt);
    check_eq("done_seen_k1_random", int'(dt > 0), 1);

    // SIZEKer=SIZE=3: single output.
    run_image(2, 3, 3, 2, 0, -1, 1'b0, dt);
    check_eq("done_cycle_kfull", dt, 13);
    run_image(2, 3, 3, 2, 1, -1, 1'b1, dt);
    check_eq("done_seen_kfull_random", int'(dt > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
